// File: rtl/rr_priority_encoder.sv
// Registered N-input priority encoder with a held grant index and optional round-robin fairness.
// Latency: one cycle from sampling i to o/gnt/v; no combinational path from i to any output.
// Backpressure: a valid grant is held while rdy=0; with en=1 and rdy=1 it issues one grant per cycle.
// Build option: define PENC_ROUND_ROBIN_EN to compile in the rotation pointer and the round-robin search.
module rr_priority_encoder #(
  parameter  int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] i,
  input  logic         rdy,
  output logic [W-1:0] o,
  output logic [N-1:0] gnt,
  output logic         v
);

  logic         load;
  logic         accept;
  logic [W-1:0] high_all;
  logic [W-1:0] win;
  logic [W-1:0] o_nxt;
  logic [N-1:0] gnt_nxt;
  logic         v_nxt;

  // A new sample is taken when idle, or when the held grant is consumed this edge.
  assign load   = en & (~v | rdy);
  assign accept = v & rdy;

`ifdef PENC_ROUND_ROBIN_EN
  logic [W-1:0] ptr;
  logic [W-1:0] base;
  logic [W-1:0] high_low;
  logic         hit_low;

  // The grant being accepted this edge already counts as the last winner, so
  // back-to-back grants rotate without a bubble.
  assign base = accept ? o : ptr;

  // Rotation pointer remembers the index of the last accepted grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= o;
    end
  end

  // Highest request overall, and highest request strictly below the rotation base.
  always_comb begin
    high_all = '0;
    high_low = '0;
    hit_low  = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (i[j]) begin
        high_all = W'(j);
        if (j < int'(base)) begin
          high_low = W'(j);
          hit_low  = 1'b1;
        end
      end
    end
  end

  // Search runs base-1 down to 0 first; if nothing there, the highest overall
  // request is necessarily at or above base, which completes the wrap.
  assign win = hit_low ? high_low : high_all;
`else
  // Fixed priority: highest requesting index wins.
  always_comb begin
    high_all = '0;
    for (int j = 0; j < N; j++) begin
      if (i[j]) begin
        high_all = W'(j);
      end
    end
  end

  assign win = high_all;
`endif

  // Next grant: reload on load, drop to idle when accepted without a new sample, else hold.
  always_comb begin
    o_nxt   = o;
    gnt_nxt = gnt;
    v_nxt   = v;
    if (load) begin
      o_nxt   = '0;
      gnt_nxt = '0;
      v_nxt   = |i;
      if (|i) begin
        o_nxt   = win;
        gnt_nxt = {{(N-1){1'b0}}, 1'b1} << win;
      end
    end else if (accept) begin
      o_nxt   = '0;
      gnt_nxt = '0;
      v_nxt   = 1'b0;
    end
  end

  // Output registers; v doubles as the IDLE/HOLD state bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o   <= '0;
      gnt <= '0;
      v   <= 1'b0;
    end else begin
      o   <= o_nxt;
      gnt <= gnt_nxt;
      v   <= v_nxt;
    end
  end

endmodule
